// File: rtl/mrd_sequencer.sv
// mrd_sequencer: steps the MRD detector datapath through its four stages
// (pre-process, MRD init rounds, M*b generation, K refinement iterations)
// with per-stage enables, first-cycle load strobes, busy/done and progress.
module mrd_sequencer #(
  parameter int PRE_LAT     = 16,
  parameter int INIT_ROUNDS = 2,
  parameter int INIT_LAT    = 8,
  parameter int MB_LAT      = 4,
  parameter int ITER_LAT    = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] num_iter,
  input  logic       abort,
  output logic       pre_en,
  output logic       init_en,
  output logic       init_load,
  output logic       mb_en,
  output logic       iter_en,
  output logic       iter_load,
  output logic       busy,
  output logic       done,
  output logic [2:0] state,
  output logic [4:0] round
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_INIT = 3'd2,
    S_MB   = 3'd3,
    S_ITER = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Counter reload values: a phase of LAT cycles counts LAT-1 down to 0.
  localparam logic [CNT_W-1:0] PRE_LD     = CNT_W'(PRE_LAT - 1);
  localparam logic [CNT_W-1:0] INIT_LD    = CNT_W'(INIT_LAT - 1);
  localparam logic [CNT_W-1:0] MB_LD      = CNT_W'(MB_LAT - 1);
  localparam logic [CNT_W-1:0] ITER_LD    = CNT_W'(ITER_LAT - 1);
  localparam logic [4:0]       INIT_LAST  = 5'(INIT_ROUNDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_round;
  logic [4:0]       r_k;
  logic             r_pre_en, r_init_en, r_init_load, r_mb_en;
  logic             r_iter_en, r_iter_load, r_busy, r_done;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [4:0]       w_round_nxt;
  logic [4:0]       w_k_nxt;
  logic             w_init_load_nxt;
  logic             w_iter_load_nxt;
  logic             w_last;

  assign w_last = (r_cnt == '0);

  // Next-state, counter, round and load-strobe decisions for the phase FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_round_nxt     = r_round;
    w_k_nxt         = r_k;
    w_init_load_nxt = 1'b0;
    w_iter_load_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_state_nxt = S_PRE;
          w_k_nxt     = (num_iter == 4'd0) ? 5'd16 : {1'b0, num_iter};
          w_cnt_nxt   = PRE_LD;
        end
      end
      S_PRE: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_round_nxt = '0;
        end else if (w_last) begin
          w_state_nxt     = S_INIT;
          w_round_nxt     = '0;
          w_cnt_nxt       = INIT_LD;
          w_init_load_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      S_INIT: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_round_nxt = '0;
        end else if (w_last) begin
          if (r_round < INIT_LAST) begin
            w_round_nxt = r_round + 5'd1;
            w_cnt_nxt   = INIT_LD;
          end else begin
            w_state_nxt = S_MB;
            w_round_nxt = '0;
            w_cnt_nxt   = MB_LD;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      S_MB: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_round_nxt = '0;
        end else if (w_last) begin
          w_state_nxt     = S_ITER;
          w_round_nxt     = '0;
          w_cnt_nxt       = ITER_LD;
          w_iter_load_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      S_ITER: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_round_nxt = '0;
        end else if (w_last) begin
          if (r_round < (r_k - 5'd1)) begin
            w_round_nxt = r_round + 5'd1;
            w_cnt_nxt   = ITER_LD;
          end else begin
            w_state_nxt = S_DONE;
            w_round_nxt = '0;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_round_nxt = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_round_nxt = '0;
      end
    endcase
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_round     <= '0;
      r_k         <= '0;
      r_pre_en    <= 1'b0;
      r_init_en   <= 1'b0;
      r_init_load <= 1'b0;
      r_mb_en     <= 1'b0;
      r_iter_en   <= 1'b0;
      r_iter_load <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_round     <= w_round_nxt;
      r_k         <= w_k_nxt;
      r_pre_en    <= (w_state_nxt == S_PRE);
      r_init_en   <= (w_state_nxt == S_INIT);
      r_init_load <= w_init_load_nxt;
      r_mb_en     <= (w_state_nxt == S_MB);
      r_iter_en   <= (w_state_nxt == S_ITER);
      r_iter_load <= w_iter_load_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
    end
  end

  assign pre_en    = r_pre_en;
  assign init_en   = r_init_en;
  assign init_load = r_init_load;
  assign mb_en     = r_mb_en;
  assign iter_en   = r_iter_en;
  assign iter_load = r_iter_load;
  assign busy      = r_busy;
  assign done      = r_done;
  assign state     = r_state;
  assign round     = r_round;

endmodule

// File: tb/tb_mrd_sequencer.sv
// tb_mrd_sequencer: checks mrd_sequencer (default parameters and an
// all-LAT=1 override) against a timeline model built from phase spans.
module tb_mrd_sequencer;

  localparam int PL = 16, IR = 2, IL = 8, ML = 4, ITL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_start, a_abort, b_start, b_abort;
  logic [3:0] a_num, b_num;
  logic       a_pre, a_init, a_iload, a_mb, a_iter, a_itload, a_busy, a_done;
  logic       b_pre, b_init, b_iload, b_mb, b_iter, b_itload, b_busy, b_done;
  logic [2:0] a_state, b_state;
  logic [4:0] a_round, b_round;

  int n_assert = 0;
  int n_fail   = 0;

  mrd_sequencer u_dut_a (
    .clk(clk), .rst(rst), .start(a_start), .num_iter(a_num), .abort(a_abort),
    .pre_en(a_pre), .init_en(a_init), .init_load(a_iload), .mb_en(a_mb),
    .iter_en(a_iter), .iter_load(a_itload), .busy(a_busy), .done(a_done),
    .state(a_state), .round(a_round)
  );

  mrd_sequencer #(
    .PRE_LAT(1), .INIT_ROUNDS(1), .INIT_LAT(1), .MB_LAT(1), .ITER_LAT(1), .CNT_W(8)
  ) u_dut_b (
    .clk(clk), .rst(rst), .start(b_start), .num_iter(b_num), .abort(b_abort),
    .pre_en(b_pre), .init_en(b_init), .init_load(b_iload), .mb_en(b_mb),
    .iter_en(b_iter), .iter_load(b_itload), .busy(b_busy), .done(b_done),
    .state(b_state), .round(b_round)
  );

  // Observed vector: {state, round, busy, done, pre, init, iload, mb, iter, itload}
  function logic [15:0] obs(input int sel);
    if (sel == 0)
      return {a_state, a_round, a_busy, a_done, a_pre, a_init, a_iload, a_mb, a_iter, a_itload};
    return {b_state, b_round, b_busy, b_done, b_pre, b_init, b_iload, b_mb, b_iter, b_itload};
  endfunction

  function automatic int latency(input int sel, input int k);
    if (sel == 0) return 1 + PL + IR * IL + ML + k * ITL;
    return 1 + 1 + 1 + 1 + k;
  endfunction

  // Expected outputs t cycles after the accepted-start edge, from phase spans.
  function automatic logic [15:0] model(input int t, input int k, input int sel);
    int pl, ir, il, ml, itl, a;
    logic [4:0] rd;
    pl = (sel == 0) ? PL : 1;  ir = (sel == 0) ? IR : 1;
    il = (sel == 0) ? IL : 1;  ml = (sel == 0) ? ML : 1;
    itl = (sel == 0) ? ITL : 1;
    a = t;
    if (a < 1) return '0;
    if (a <= pl) return {3'd1, 5'd0, 8'b1010_0000};
    a = a - pl;
    if (a <= ir * il) begin
      rd = 5'((a - 1) / il);
      return {3'd2, rd, 1'b1, 1'b0, 1'b0, 1'b1, (a == 1), 3'b000};
    end
    a = a - ir * il;
    if (a <= ml) return {3'd3, 5'd0, 8'b1000_0100};
    a = a - ml;
    if (a <= k * itl) begin
      rd = 5'((a - 1) / itl);
      return {3'd4, rd, 6'b100000, 1'b1, (a == 1)};
    end
    a = a - k * itl;
    if (a == 1) return {3'd5, 5'd0, 8'b1100_0000};
    return '0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic st, input logic [3:0] nm, input logic ab);
    if (sel == 0) begin a_start = st; a_num = nm; a_abort = ab; end
    else begin b_start = st; b_num = nm; b_abort = ab; end
  endtask

  // One request: start on the next edge, optional abort/rst at cycle kill,
  // optional random start/num_iter noise while the run is busy.
  task automatic run_case(input int sel, input int ni, input int abort_at,
                          input int rst_at, input bit noise, input int id);
    int k, dt, kill_t, end_t, done_seen, done_exp;
    logic [15:0] exp;
    logic st;
    k = (ni == 0) ? 16 : ni;
    dt = latency(sel, k);
    kill_t = (abort_at > 0) ? abort_at : rst_at;
    end_t = (kill_t > 0) ? kill_t + 2 : dt + 2;
    done_exp = (kill_t > 0 && kill_t < dt) ? -1 : dt;
    done_seen = -1;
    drive(sel, 1'b1, 4'(ni), 1'b0);
    for (int t = 1; t <= end_t; t++) begin
      cyc();
      exp = (kill_t > 0 && t > kill_t) ? 16'h0 : model(t, k, sel);
      check($sformatf("run%0d_t%0d", id, t), {16'h0, obs(sel)}, {16'h0, exp});
      if (obs(sel)[6] && done_seen < 0) done_seen = t;
      st = (noise && t <= dt && !(kill_t > 0 && t >= kill_t)) ? 1'($urandom_range(0, 1)) : 1'b0;
      drive(sel, st, noise ? 4'($urandom_range(0, 15)) : 4'(ni), (t == abort_at));
      rst = (rst_at > 0 && t == rst_at);
    end
    rst = 1'b0;
    drive(sel, 1'b0, 4'd0, 1'b0);
    check($sformatf("run%0d_done_cycle", id), done_seen, done_exp);
  endtask

  initial begin
    int dcyc[$];
    int ni, ab;
    rst = 1'b1;
    drive(0, 1'b0, 4'd0, 1'b0);
    drive(1, 1'b0, 4'd0, 1'b0);
    repeat (2) cyc();
    check("reset_a", {16'h0, obs(0)}, 32'h0);
    check("reset_b", {16'h0, obs(1)}, 32'h0);
    rst = 1'b0;
    cyc();
    check("idle_a", {16'h0, obs(0)}, 32'h0);

    run_case(0, 3, 0, 0, 0, 1);   // done at 49
    run_case(0, 0, 0, 0, 0, 2);   // K=16, done at 101
    run_case(0, 5, 20, 0, 0, 3);  // abort in INIT
    run_case(0, 3, 0, 0, 0, 4);   // restart at cycle 22 of previous
    run_case(0, 2, 0, 35, 0, 5);  // rst in MB

    // start and abort together in IDLE
    drive(0, 1'b1, 4'd3, 1'b1);
    cyc();
    check("start_abort_idle0", {16'h0, obs(0)}, 32'h0);
    drive(0, 1'b0, 4'd0, 1'b0);
    cyc();
    check("start_abort_idle1", {16'h0, obs(0)}, 32'h0);

    // start held high, num_iter=1: back-to-back runs with period 42
    drive(0, 1'b1, 4'd1, 1'b0);
    for (int c = 1; c <= 128; c++) begin
      cyc();
      check($sformatf("b2b_c%0d", c), {16'h0, obs(0)},
            {16'h0, (c <= 126) ? model(((c - 1) % 42) + 1, 1, 0) : 16'h0});
      if (a_done) dcyc.push_back(c);
      if (c == 125) drive(0, 1'b0, 4'd0, 1'b0);
    end
    check("b2b_done_count", dcyc.size(), 3);
    if (dcyc.size() == 3) begin
      check("b2b_done0", dcyc[0], 41);
      check("b2b_done1", dcyc[1], 83);
      check("b2b_done2", dcyc[2], 125);
    end

    // randomized requests with start/num_iter noise, one with a random abort
    for (int i = 0; i < 3; i++) begin
      ni = int'($urandom_range(0, 15));
      ab = (i == 1) ? int'($urandom_range(1, latency(0, (ni == 0) ? 16 : ni) - 1)) : 0;
      run_case(0, ni, ab, 0, 1, 10 + i);
    end

    // all LAT=1, INIT_ROUNDS=1 instance
    run_case(1, 1, 0, 0, 0, 20);  // done at 5
    run_case(1, int'($urandom_range(0, 15)), 0, 0, 1, 21);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
